rgb_fade_controller: RTL and testbench
======================================

# rgb_fade_controller

Upstream duty-cycle source for the RGB PWM stage. Accepts a commanded target colour (three duty values) over a valid/ready handshake and ramps each channel's duty by one LSB per gradient tick toward its target, independently per channel. Drives three PWM channels directly; pulses `done` when all channels have arrived.

## Interface
- `resolution`, 8: PWM resolution in bits; duties span 0..2^resolution (width resolution+1).
- `gradient_max`, 2_499_999: tick divider terminal count; one gradient tick every gradient_max+1 clocks.

- `clk` in 1: single system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `tgt_r`, `tgt_g`, `tgt_b` in resolution+1: target duty per channel; sampled only on accept.
- `tgt_valid` in 1: target request.
- `tgt_ready` out 1: block can accept a target.
- `duty_r`, `duty_g`, `duty_b` out resolution+1: current duty per channel, registered, to PWM stage.
- `busy` out 1: fade in progress.
- `done` out 1: one-cycle pulse when fade completes.

## Operation
- States: IDLE, FADE.
- IDLE: `tgt_ready`=1, `busy`=0. Accept = `tgt_valid` && `tgt_ready` at a rising edge -> latch targets, clear tick counter, go FADE.
- Targets above 2^resolution are clamped to 2^resolution on latch.
- FADE: `tgt_ready`=0, `busy`=1; requests ignored (requester holds `tgt_valid` until accepted).
- On each tick in FADE, per channel: duty<target -> +1; duty>target -> -1; equal -> hold. Channels move concurrently; a channel that arrives early holds.
- When all three duties equal their targets (after the update, or at accept when already equal), return to IDLE and pulse `done`.
- Duties never wrap: arithmetic is bounded 0..2^resolution by construction (step only toward an in-range target).
- Duties hold their values in IDLE; a new target fades from the current colour, not from 0.

## Timing
- Reset values: state IDLE, all duties 0, tick counter 0, `tgt_ready`=1, `busy`=0, `done`=0.
- `tgt_ready` and `busy` are decoded from state (no extra latency).
- Tick counter: counts 0..gradient_max, tick asserted for the single cycle in which count==gradient_max, then wraps to 0; cleared on accept; counts only in FADE.
- First duty update lands on the (gradient_max+1)th rising edge after the accepting edge; subsequent updates every gradient_max+1 edges.
- A fade of N = max |target−duty| steps completes on the N·(gradient_max+1)th edge after accept; `done` is high during the following cycle, concurrent with state IDLE and `tgt_ready`=1.
- All-equal target: no duty change; `done` high in the cycle after the accepting edge.
- Accept in the same cycle `done` is high is legal (back-to-back fades).
- Reset mid-fade: all duties to 0 and IDLE immediately (async), no `done`.

## Structure
- Shared package `pwm_pkg`: `fade_state_t` enum (IDLE, FADE) and default `resolution` constant shared with the PWM stage.
- Sub-module `tick_divider` (params `gradient_max`; ports `clk`, `rst`, `clr`, `en`, `tick`) for the gradient tick; per-channel step logic stays inline.

## Test plan
Run with `gradient_max`=3, `resolution`=8.
- Reset: assert `rst` -> duties 0/0/0, `tgt_ready`=1, `busy`=0, `done`=0.
- From 0/0/0 accept (256,0,128) -> `duty_b` reaches 128 after 512 cycles and holds; `duty_r` reaches 256 at 1024 cycles; `done` one cycle later, then IDLE.
- From 256/0/128 accept (0,0,0) -> channels decrement; `duty_b` 0 at 512 cycles, `duty_r` 0 at 1024 cycles; `done` pulse once.
- Hold `tgt_valid` with (10,10,10) while busy -> `tgt_ready`=0, targets unchanged until IDLE; accepted on the cycle `done` is high.
- Accept (300,5,5) from 5/5/5 -> `duty_r` clamps at 256; accept current colour -> `done` next cycle, duties unchanged.
- Assert `rst` mid-fade at duty 100 -> duties 0, `busy`=0, no `done`.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared PWM definitions: fade FSM state encoding and default duty resolution.
// Latency: none (types and constants only).
// Backpressure: none.
package pwm_pkg;

  // Default PWM resolution in bits; duties span 0..2**RESOLUTION.
  localparam int unsigned RESOLUTION = 8;

  typedef enum logic {
    IDLE = 1'b0,
    FADE = 1'b1
  } fade_state_t;

endpackage

// File: rtl/tick_divider.sv
// Gradient tick generator: free-running modulo-(gradient_max+1) counter gated by en.
// Latency: tick is combinational from the count; first tick gradient_max+1 edges after clr.
// Backpressure: none; the counter simply holds while en is low.
//
// Ports: clk/rst (async active-high) clock and reset; clr restarts the count at 0;
//        en lets the count advance; tick is high for the one cycle the count is terminal.
module tick_divider #(
  parameter int unsigned gradient_max = 2_499_999
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (gradient_max > 0) ? $clog2(gradient_max + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(gradient_max);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == CNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rgb_fade_controller.sv
// RGB fade controller: ramps three PWM duties one LSB per gradient tick toward a commanded colour.
// Latency: N*(gradient_max+1) edges for an N-step fade; done pulses the cycle after arrival.
// Backpressure: tgt_ready is low for the whole fade; the requester holds tgt_valid until accepted.
//
// Ports: clk/rst (async active-high); tgt_r/g/b + tgt_valid/tgt_ready target handshake;
//        duty_r/g/b registered duties to the PWM stage; busy while fading; done one-cycle pulse.
module rgb_fade_controller
  import pwm_pkg::*;
#(
  parameter int unsigned resolution   = RESOLUTION,
  parameter int unsigned gradient_max = 2_499_999
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [resolution:0] tgt_r,
  input  logic [resolution:0] tgt_g,
  input  logic [resolution:0] tgt_b,
  input  logic                tgt_valid,
  output logic                tgt_ready,
  output logic [resolution:0] duty_r,
  output logic [resolution:0] duty_g,
  output logic [resolution:0] duty_b,
  output logic                busy,
  output logic                done
);

  localparam int unsigned W = resolution + 1;
  localparam logic [W-1:0] DUTY_MAX = {1'b1, {resolution{1'b0}}};
  localparam logic [W-1:0] ONE      = {{resolution{1'b0}}, 1'b1};

  function automatic logic [W-1:0] clamp(input logic [W-1:0] v);
    return (v > DUTY_MAX) ? DUTY_MAX : v;
  endfunction

  // Targets are always in range, so stepping toward one can never wrap.
  function automatic logic [W-1:0] step(input logic [W-1:0] d, input logic [W-1:0] t);
    if (d < t)      return d + ONE;
    else if (d > t) return d - ONE;
    else            return d;
  endfunction

  fade_state_t state, state_nxt;

  logic         accept;
  logic         tick;
  logic [W-1:0] lat_r, lat_g, lat_b;
  logic [W-1:0] clamp_r, clamp_g, clamp_b;
  logic [W-1:0] step_r, step_g, step_b;
  logic         eq_at_accept;
  logic         eq_after_step;

  assign accept = tgt_valid && tgt_ready;

  assign clamp_r = clamp(tgt_r);
  assign clamp_g = clamp(tgt_g);
  assign clamp_b = clamp(tgt_b);

  assign step_r = step(duty_r, lat_r);
  assign step_g = step(duty_g, lat_g);
  assign step_b = step(duty_b, lat_b);

  // A target equal to the current colour finishes at the accepting edge.
  assign eq_at_accept  = (clamp_r == duty_r) && (clamp_g == duty_g) && (clamp_b == duty_b);
  assign eq_after_step = (step_r == lat_r) && (step_g == lat_g) && (step_b == lat_b);

  tick_divider #(
    .gradient_max (gradient_max)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .en   (state == FADE),
    .tick (tick)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept && !eq_at_accept) state_nxt = FADE;
      FADE: if (tick && eq_after_step)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded straight from state
  always_comb begin
    tgt_ready = (state == IDLE);
    busy      = (state == FADE);
  end

  // Target latch, duty stepping and completion pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_r  <= '0;
      lat_g  <= '0;
      lat_b  <= '0;
      duty_r <= '0;
      duty_g <= '0;
      duty_b <= '0;
      done   <= 1'b0;
    end else begin
      if (accept) begin
        lat_r <= clamp_r;
        lat_g <= clamp_g;
        lat_b <= clamp_b;
      end
      if ((state == FADE) && tick) begin
        duty_r <= step_r;
        duty_g <= step_g;
        duty_b <= step_b;
      end
      done <= (accept && eq_at_accept) || ((state == FADE) && tick && eq_after_step);
    end
  end

endmodule

// File: tb/tb_rgb_fade_controller.sv
// Bench for rgb_fade_controller with gradient_max=3 (one step every 4 edges), resolution=8.
// Latency: n/a.
// Backpressure: n/a.
module tb_rgb_fade_controller;

  localparam int PER = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] tgt_r, tgt_g, tgt_b;
  logic       tgt_valid;
  logic       tgt_ready;
  logic [8:0] duty_r, duty_g, duty_b;
  logic       busy;
  logic       done;

  int n_tests = 0;
  int n_fail  = 0;

  rgb_fade_controller #(
    .resolution   (8),
    .gradient_max (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tgt_r     (tgt_r),
    .tgt_g     (tgt_g),
    .tgt_b     (tgt_b),
    .tgt_valid (tgt_valid),
    .tgt_ready (tgt_ready),
    .duty_r    (duty_r),
    .duty_g    (duty_g),
    .duty_b    (duty_b),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    tr, tg, tb;   // commanded target
    int    er, eg, eb;   // expected final (clamped) duties
    int    edges;        // edge after accept on which the fade completes
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Duty expected k edges after accept: one step per PER edges, stopping at the target.
  function automatic int exp_duty(input int s, input int t, input int k);
    int n;
    n = k / PER;
    if (s < t) return s + ((n < t - s) ? n : t - s);
    else       return s - ((n < s - t) ? n : s - t);
  endfunction

  // Present a target and let it be accepted; returns #1 after the accepting edge.
  task automatic launch(input string name, input int r, input int g, input int b);
    check({name, " ready_before_accept"}, {31'd0, tgt_ready}, 32'd1);
    tgt_r     = 9'(r);
    tgt_g     = 9'(g);
    tgt_b     = 9'(b);
    tgt_valid = 1'b1;
    @(posedge clk);
    #1;
    tgt_valid = 1'b0;
  endtask

  // Follow a fade edge by edge from #1 after the accepting edge until done (bounded).
  task automatic trace(input string name, input int sr, input int sg, input int sb,
                       input int er, input int eg, input int eb, input int edges);
    int bad;
    int done_k;
    bad    = 0;
    done_k = -1;
    for (int k = 0; k <= edges + 8; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (done) begin
        done_k = k;
        break;
      end
      if (duty_r !== 9'(exp_duty(sr, er, k)) || duty_g !== 9'(exp_duty(sg, eg, k)) ||
          duty_b !== 9'(exp_duty(sb, eb, k)) || busy !== 1'b1 || tgt_ready !== 1'b0) begin
        if (bad == 0)
          $display("FAIL %s trajectory at edge %0d: duty %0d/%0d/%0d busy %0d ready %0d, expected %0d/%0d/%0d busy 1 ready 0",
                   name, k, duty_r, duty_g, duty_b, busy, tgt_ready,
                   exp_duty(sr, er, k), exp_duty(sg, eg, k), exp_duty(sb, eb, k));
        bad++;
      end
    end
    check({name, " trajectory_errors"}, bad, 0);
    check({name, " done_edge"}, done_k, edges);
    check({name, " final_r"}, {23'd0, duty_r}, er);
    check({name, " final_g"}, {23'd0, duty_g}, eg);
    check({name, " final_b"}, {23'd0, duty_b}, eb);
    check({name, " busy_at_done"}, {31'd0, busy}, 0);
    check({name, " ready_at_done"}, {31'd0, tgt_ready}, 1);
  endtask

  initial begin
    int cr, cg, cb;
    int w;
    int seen;

    vecs[0] = '{"up_256_0_128",   256, 0, 128, 256, 0, 128, 1024};
    vecs[1] = '{"down_to_0",        0, 0,   0,   0, 0,   0, 1024};
    vecs[2] = '{"up_5",             5, 5,   5,   5, 5,   5,   20};
    vecs[3] = '{"clamp_300",      300, 5,   5, 256, 5,   5, 1004};
    vecs[4] = '{"equal_target",   256, 5,   5, 256, 5,   5,    0};
    vecs[5] = '{"mixed_dirs",     250, 7,   0, 250, 7,   0,   24};
    vecs[6] = '{"clamp_511",      511, 0,   0, 256, 0,   0,   28};

    rst       = 1'b1;
    tgt_valid = 1'b0;
    tgt_r     = '0;
    tgt_g     = '0;
    tgt_b     = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset duty_r", {23'd0, duty_r}, 0);
    check("reset duty_g", {23'd0, duty_g}, 0);
    check("reset duty_b", {23'd0, duty_b}, 0);
    check("reset tgt_ready", {31'd0, tgt_ready}, 1);
    check("reset busy", {31'd0, busy}, 0);
    check("reset done", {31'd0, done}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven fades, each starting from the previous colour
    cr = 0; cg = 0; cb = 0;
    for (int i = 0; i < 7; i++) begin
      launch(vecs[i].name, vecs[i].tr, vecs[i].tg, vecs[i].tb);
      trace(vecs[i].name, cr, cg, cb, vecs[i].er, vecs[i].eg, vecs[i].eb, vecs[i].edges);
      @(posedge clk);
      #1;
      check({vecs[i].name, " done_one_cycle"}, {31'd0, done}, 0);
      cr = vecs[i].er; cg = vecs[i].eg; cb = vecs[i].eb;
    end

    // Request held while busy, accepted in the done cycle (back-to-back)
    launch("b2b_first", 252, 0, 0);
    tgt_r     = 9'd10;
    tgt_g     = 9'd10;
    tgt_b     = 9'd10;
    tgt_valid = 1'b1;
    trace("b2b_first", 256, 0, 0, 252, 0, 0, 16);
    @(posedge clk);
    #1;
    tgt_valid = 1'b0;
    check("b2b accepted busy", {31'd0, busy}, 1);
    check("b2b done_one_cycle", {31'd0, done}, 0);
    trace("b2b_second", 252, 0, 0, 10, 10, 10, 968);
    @(posedge clk);
    #1;

    // Reset in the middle of a fade once duty_r reaches 100
    launch("reset_mid", 200, 200, 200);
    w = 0;
    while (duty_r != 9'd100 && w < 400) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("reset_mid edges_to_100", w, 90 * PER);
    #2;
    rst = 1'b1;
    #1;
    check("reset_mid duty_r", {23'd0, duty_r}, 0);
    check("reset_mid duty_g", {23'd0, duty_g}, 0);
    check("reset_mid duty_b", {23'd0, duty_b}, 0);
    check("reset_mid busy", {31'd0, busy}, 0);
    check("reset_mid tgt_ready", {31'd0, tgt_ready}, 1);
    seen = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    check("reset_mid no_done", seen, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("after_reset duty_r", {23'd0, duty_r}, 0);
    check("after_reset done", {31'd0, done}, 0);

    // Short fade after reset starts from 0/0/0
    launch("post_reset", 1, 0, 2);
    trace("post_reset", 0, 0, 0, 1, 0, 2, 8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
